fetch_sequencer: RTL



---
 rtl/fetch_sequencer_if.sv | 36 +++
 rtl/fetch_sequencer.sv | 115 +++++++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: groups the fetch sequencer's bus signals.
//   run                        - fetch enable from the datapath
//   mem_addr / mem_byte        - byte-wide combinational instruction memory port
//   instr / instr_pc /
//   instr_valid / instr_ready  - instruction handshake towards decode
//   redirect_valid /
//   redirect_pc / align_err    - branch/jump redirect and misalignment pulse
//   fetch_count / busy         - status
// Modport master is the sequencer side; slave is the memory/decode/datapath side.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              run;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_byte;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              align_err;
    logic [CNT_W-1:0]  fetch_count;
    logic              busy;

    modport master (
        input  run, mem_byte, instr_ready, redirect_valid, redirect_pc,
        output mem_addr, instr, instr_pc, instr_valid, align_err, fetch_count, busy
    );

    modport slave (
        output run, mem_byte, instr_ready, redirect_valid, redirect_pc,
        input  mem_addr, instr, instr_pc, instr_valid, align_err, fetch_count, busy
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller for a byte-wide instruction
// memory. Owns the PC, reads four consecutive bytes (MSB at the lowest
// address) into a 32-bit instruction, offers it to decode over valid/ready,
// takes redirects from the datapath and counts accepted instructions.
// Ports:
//   clk   - clock, all state on the rising edge
//   reset - synchronous, active-high
//   bus   - fetch_sequencer_if.master (memory port, decode handshake,
//           redirect, status)
module fetch_sequencer #(
    parameter int                ADDR_W   = 5,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    fetch_sequencer_if.master  bus
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} stateE;

    stateE             state, stateNext;
    logic [ADDR_W-1:0] pc, pcNext;
    logic [1:0]        byteCnt, byteCntNext;
    logic [31:0]       asmReg, asmNext;
    logic [ADDR_W-1:0] instrPc, instrPcNext;
    logic              alignErr, alignErrNext;
    logic [CNT_W-1:0]  fetchCount, countNext;
    logic              accept;

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            byteCnt    <= 2'd0;
            asmReg     <= 32'd0;
            instrPc    <= '0;
            alignErr   <= 1'b0;
            fetchCount <= '0;
        end else begin
            state      <= stateNext;
            pc         <= pcNext;
            byteCnt    <= byteCntNext;
            asmReg     <= asmNext;
            instrPc    <= instrPcNext;
            alignErr   <= alignErrNext;
            fetchCount <= countNext;
        end
    end

    // Next-state and datapath update
    always_comb begin
        stateNext    = state;
        pcNext       = pc;
        byteCntNext  = byteCnt;
        asmNext      = asmReg;
        instrPcNext  = instrPc;
        alignErrNext = 1'b0;
        countNext    = fetchCount;
        accept       = (state == HOLD) && bus.instr_ready;

        if (bus.redirect_valid) begin
            // Redirect wins over everything except reset; a handshake in the
            // same cycle still counts, but the PC follows the redirect.
            pcNext       = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
            byteCntNext  = 2'd0;
            stateNext    = bus.run ? FETCH : IDLE;
            alignErrNext = |bus.redirect_pc[1:0];
            if (accept) countNext = fetchCount + 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.run) begin
                        stateNext   = FETCH;
                        byteCntNext = 2'd0;
                    end
                end
                FETCH: begin
                    unique case (byteCnt)
                        2'd0: asmNext[31:24] = bus.mem_byte;
                        2'd1: asmNext[23:16] = bus.mem_byte;
                        2'd2: asmNext[15:8]  = bus.mem_byte;
                        2'd3: asmNext[7:0]   = bus.mem_byte;
                        default: ;
                    endcase
                    // Wraps 3 -> 0, which is where the next fetch starts.
                    byteCntNext = byteCnt + 2'd1;
                    if (byteCnt == 2'd3) begin
                        stateNext   = HOLD;
                        instrPcNext = pc;
                    end
                end
                HOLD: begin
                    if (bus.instr_ready) begin
                        countNext = fetchCount + 1'b1;
                        pcNext    = pc + ADDR_W'(4);
                        stateNext = bus.run ? FETCH : IDLE;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // Outputs: valid is exactly "sitting in HOLD", so any exit drops it.
    assign bus.mem_addr    = pc + ADDR_W'(byteCnt);
    assign bus.instr       = asmReg;
    assign bus.instr_pc    = instrPc;
    assign bus.instr_valid = (state == HOLD);
    assign bus.align_err   = alignErr;
    assign bus.fetch_count = fetchCount;
    assign bus.busy        = (state != IDLE);

endmodule
